bht_update_scheduler: RTL

//  Sequences the branch history table's single write port. Sits between EX and the table.

---
 rtl/bht_update_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bht_update_scheduler.sv
// Write-port sequencer for the branch history table: initialisation walk, EX update FIFO, prediction gating.
// Optional statistics counters are built only when BHT_SCHED_STATS_EN is defined.
module bht_update_scheduler #(
  parameter int INDEX_WIDTH = 6,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_req,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic                   upd_taken,
  input  logic                   tbl_ready,
  output logic                   tbl_we,
  output logic [INDEX_WIDTH-1:0] tbl_index,
  output logic                   tbl_init,
  output logic                   tbl_taken,
  output logic                   pred_en,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic [CNT_WIDTH-1:0]   upd_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = 1;
  localparam logic [PTR_W-1:0]       PTR_ONE  = 1;
  localparam logic [PTR_W:0]         OCC_ONE  = 1;
  localparam logic [PTR_W:0]         OCC_FULL = (PTR_W+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {BOOT, INIT, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [INDEX_WIDTH-1:0]  init_idx_reg, init_idx_next;
  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]          occ_reg, occ_next;

  logic [INDEX_WIDTH-1:0]  slot_index [QUEUE_DEPTH];
  logic                    slot_taken [QUEUE_DEPTH];

  logic fifo_empty, fifo_full, accept, pop, push;
  logic unused_pc;

  assign unused_pc  = ^{upd_pc[31:2+INDEX_WIDTH], upd_pc[1:0]};
  assign fifo_empty = (occ_reg == '0);
  assign fifo_full  = (occ_reg == OCC_FULL);
  assign accept     = tbl_we && tbl_ready;
  assign pop        = (state_reg == RUN) && accept;
  // A full FIFO still takes the new entry when the head leaves on the same edge.
  assign push       = (state_reg == RUN) && upd_valid && !flush_req && (!fifo_full || pop);
  assign busy       = (state_reg != RUN) || !fifo_empty;

  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
    logic [INDEX_WIDTH-1:0] index_reg;
    logic                   taken_reg;

    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        index_reg <= upd_pc[2 +: INDEX_WIDTH];
        taken_reg <= upd_taken;
      end
    end

    assign slot_index[gi] = index_reg;
    assign slot_taken[gi] = taken_reg;
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_index = init_idx_reg;
    tbl_init  = 1'b0;
    tbl_taken = 1'b0;
    pred_en   = 1'b0;
    case (state_reg)
      INIT: begin
        tbl_we   = 1'b1;
        tbl_init = 1'b1;
      end
      RUN: begin
        pred_en   = 1'b1;
        tbl_we    = !fifo_empty;
        tbl_index = slot_index[rd_ptr_reg];
        tbl_taken = slot_taken[rd_ptr_reg];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    occ_next      = occ_reg;
    case (state_reg)
      BOOT: state_next = INIT;
      INIT: begin
        if (accept) begin
          if (init_idx_reg == IDX_LAST) begin
            state_next    = RUN;
            init_idx_next = '0;
          end else begin
            init_idx_next = init_idx_reg + IDX_ONE;
          end
        end
      end
      RUN: begin
        if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
        case ({push, pop})
          2'b10:   occ_next = occ_reg + OCC_ONE;
          2'b01:   occ_next = occ_reg - OCC_ONE;
          default: ;
        endcase
      end
      default: state_next = BOOT;
    endcase
    // Flush overrides everything, including a same-cycle push.
    if (flush_req) begin
      state_next    = INIT;
      init_idx_next = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      occ_next      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      init_idx_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      occ_reg      <= occ_next;
    end
  end

`ifdef BHT_SCHED_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic                 drop;
  logic [CNT_WIDTH-1:0] drop_cnt_reg, upd_cnt_reg;

  assign drop = (state_reg == RUN) && upd_valid && !flush_req && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_reg <= '0;
      upd_cnt_reg  <= '0;
    end else begin
      if (drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
      if (pop && (upd_cnt_reg != '1))   upd_cnt_reg  <= upd_cnt_reg + CNT_ONE;
    end
  end

  assign drop_count = drop_cnt_reg;
  assign upd_count  = upd_cnt_reg;
`else
  assign drop_count = '0;
  assign upd_count  = '0;
`endif

endmodule
